// File: rtl/div_tick_meter.sv
// Resynchronises a divided clock into one-cycle ticks, counts them modulo a
// programmable terminal and measures the tick period in system clocks.
module div_tick_meter #(
   parameter int CNT_W = 16,
   parameter int PER_W = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             div_in,
   input  logic             en,
   input  logic [CNT_W-1:0] terminal,
   output logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             wrap,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             overflow
);

   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam logic [PER_W-1:0] PCNT_MAX = '1;
   localparam logic [PER_W-1:0] PCNT_ONE = PER_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic              s1_q, s2_q, s3_q;
   logic [1:0]        fill_q;
   logic              tick_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wrap_q, wrap_d;
   logic [PER_W-1:0]  pcnt_q, pcnt_d;
   logic [PER_W-1:0]  period_q, period_d;
   logic              pv_q, pv_d;
   logic              ovf_q, ovf_d;
   logic              arm_tick, meas_run, meas_tick;

   // fill_q blocks edge detection until s3 holds a real sample, so a div_in
   // already high at reset release cannot masquerade as a rising edge.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         fill_q <= 2'd0;
         tick_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the chain.
         s1_q   <= div_in;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
         tick_q <= s2_q & ~s3_q & (fill_q == 2'd3);
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ARM;
            ARM:     if (tick_q) state_d = MEAS;
            MEAS:    state_d = MEAS;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      arm_tick  = 1'b0;
      meas_run  = 1'b0;
      meas_tick = 1'b0;
      if (en) begin
         case (state_q)
            ARM:  arm_tick = tick_q;
            MEAS: begin
               meas_run  = 1'b1;
               meas_tick = tick_q;
            end
            default: ;
         endcase
      end
   end

   // Period meter: pcnt falls back to 0 whenever not armed or measuring.
   always_comb begin
      pcnt_d   = '0;
      period_d = period_q;
      pv_d     = 1'b0;
      ovf_d    = ovf_q & en;
      if (arm_tick) begin
         pcnt_d = PCNT_ONE;
      end else if (meas_run) begin
         if (meas_tick) begin
            pcnt_d   = PCNT_ONE;
            period_d = pcnt_q;
            pv_d     = 1'b1;
            if (pcnt_q == PCNT_MAX) ovf_d = 1'b1;
         end else begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? PCNT_MAX : pcnt_q + PCNT_ONE;
         end
      end
   end

   // >= rather than == so a terminal lowered below count wraps on the next tick.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (en && tick_q) begin
         if (count_q >= terminal) begin
            count_d = '0;
            wrap_d  = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         count_q  <= '0;
         wrap_q   <= 1'b0;
         pcnt_q   <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         wrap_q   <= wrap_d;
         pcnt_q   <= pcnt_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         ovf_q    <= ovf_d;
      end
   end

   assign tick         = tick_q;
   assign count        = count_q;
   assign wrap         = wrap_q;
   assign period       = period_q;
   assign period_valid = pv_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_div_tick_meter.sv
// Bench for div_tick_meter: a timestamp-based reference model checks a default
// instance and a 4-bit-period instance alongside directed scenario checks.
module tb_div_tick_meter;

   localparam int CNT_W = 16;
   localparam int PER_W = 16;
   localparam int PER_S = 4;
   localparam int VW    = CNT_W + PER_W + 4;
   localparam int SW    = CNT_W + PER_S + 4;
   localparam int unsigned PMAX  = (1 << PER_W) - 1;
   localparam int unsigned PMAX4 = (1 << PER_S) - 1;

   logic             clock = 1'b0;
   logic             rst = 1'b1;
   logic             div_in = 1'b0;
   logic             en = 1'b0;
   logic [CNT_W-1:0] terminal = '0;

   logic             tick, wrap, period_valid, overflow;
   logic [CNT_W-1:0] count;
   logic [PER_W-1:0] period;
   logic             s_tick, s_wrap, s_pv, s_ovf;
   logic [CNT_W-1:0] s_count;
   logic [PER_S-1:0] s_period;

   int n_checks = 0;
   int n_fail   = 0;

   div_tick_meter #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
      .clock(clock), .rst(rst), .div_in(div_in), .en(en), .terminal(terminal),
      .tick(tick), .count(count), .wrap(wrap), .period(period),
      .period_valid(period_valid), .overflow(overflow)
   );

   div_tick_meter #(.CNT_W(CNT_W), .PER_W(PER_S)) dut_s (
      .clock(clock), .rst(rst), .div_in(div_in), .en(en), .terminal(terminal),
      .tick(s_tick), .count(s_count), .wrap(s_wrap), .period(s_period),
      .period_valid(s_pv), .overflow(s_ovf)
   );

   always #5 clock = ~clock;

   // Reference model: tick from sampled div_in history, period from tick timestamps.
   int               hist[$];
   int unsigned      cyc, t_start, m_len;
   int               mode;   // 0 disabled, 1 waiting for first tick, 2 measuring
   logic             m_t, m_tick, m_wrap, m_pv, m_ovf, m_ovf4;
   logic [CNT_W-1:0] m_count;
   logic [PER_W-1:0] m_period;
   logic [PER_S-1:0] m_period4;

   initial forever begin
      @(posedge clock or negedge rst);
      if (!rst) begin
         hist = '{-1, -1, -1};
         cyc = 0; t_start = 0; mode = 0;
         m_tick = 0; m_wrap = 0; m_pv = 0; m_ovf = 0; m_ovf4 = 0;
         m_count = '0; m_period = '0; m_period4 = '0;
      end else begin
         m_t = m_tick;
         cyc++;
         m_wrap = 0;
         m_pv   = 0;
         if (!en) begin
            mode = 0; m_ovf = 0; m_ovf4 = 0;
         end else begin
            if (m_t) begin
               if (m_count >= terminal) begin m_count = '0; m_wrap = 1; end
               else m_count = m_count + 1'b1;
            end
            if (mode == 0) mode = 1;
            else if (mode == 1) begin
               if (m_t) begin mode = 2; t_start = cyc; end
            end else if (m_t) begin
               m_len     = cyc - t_start;
               m_period  = (m_len > PMAX)  ? PER_W'(PMAX)  : PER_W'(m_len);
               m_period4 = (m_len > PMAX4) ? PER_S'(PMAX4) : PER_S'(m_len);
               if (m_len >= PMAX)  m_ovf  = 1;
               if (m_len >= PMAX4) m_ovf4 = 1;
               m_pv    = 1;
               t_start = cyc;
            end
         end
         hist.push_back(int'(div_in));
         m_tick = (hist[$-2] == 1) && (hist[$-3] == 0);
         if (hist.size() > 8) void'(hist.pop_front());
      end
   end

   logic [VW-1:0] dut_vec, mdl_vec;
   logic [SW-1:0] sat_vec, msat_vec;
   assign dut_vec  = {tick, count, wrap, period, period_valid, overflow};
   assign mdl_vec  = {m_tick, m_count, m_wrap, m_period, m_pv, m_ovf};
   assign sat_vec  = {s_tick, s_count, s_wrap, s_period, s_pv, s_ovf};
   assign msat_vec = {m_tick, m_count, m_wrap, m_period4, m_pv, m_ovf4};

   // Square-wave driver, updated on the falling edge.
   int hi_len = 5, lo_len = 5, ph = 0;

   task automatic set_wave(input int hi, input int lo);
      hi_len = hi;
      lo_len = lo;
      ph     = hi;
   endtask

   task automatic step();
      @(negedge clock);
      div_in = (ph < hi_len);
      ph = (ph + 1) % (hi_len + lo_len);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         div_in = i[1];
         n_checks++;
         if (dut_vec !== '0 || sat_vec !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: dut=%h sat=%h required 0", dut_vec, sat_vec);
         end
      end
      div_in = 1'b1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         n_checks++;
         if (dut_vec !== '0 || dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL reset_release_high: dut=%h model=%h required 0", dut_vec, mdl_vec);
         end
      end
      div_in = 1'b0;
      repeat (3) @(negedge clock);
      div_in = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clock);
         n_checks++;
         if (tick !== (j == 2) || count !== '0) begin
            n_fail++;
            $display("FAIL tick_latency[%0d]: tick=%b count=%0d required tick=%b count=0", j, tick, count, j == 2);
         end
      end
   endtask

   task automatic test_period();
      int  k = 0;
      logic prev = tick;
      terminal = 3;
      en = 1'b1;
      set_wave(5, 5);
      for (int i = 0; i < 80; i++) begin
         step();
         n_checks++;
         if (dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL period_model: dut=%h model=%h", dut_vec, mdl_vec);
         end
         if (prev) k++;
         n_checks++;
         if (prev && (count !== CNT_W'(k % 4) || wrap !== (k % 4 == 0) || period_valid !== (k >= 2)
                      || (k >= 2 && period !== 16'd10))) begin
            n_fail++;
            $display("FAIL period_tick%0d: count=%0d wrap=%b pv=%b period=%0d required count=%0d wrap=%b pv=%b period=10",
                     k, count, wrap, period_valid, period, k % 4, k % 4 == 0, k >= 2);
         end else if (!prev && (wrap !== 1'b0 || period_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL period_idle: wrap=%b pv=%b required 0 0", wrap, period_valid);
         end
         prev = tick;
      end
      n_checks++;
      if (k < 6) begin
         n_fail++;
         $display("FAIL period_tick_count: got %0d ticks required at least 6", k);
      end
   endtask

   task automatic test_terminal();
      logic found = 1'b0;
      logic prev;
      terminal = 9;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (count == 16'd5) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL term_reach5: count=%0d required 5 within bound", count);
      end
      terminal = 2;
      found = 1'b0;
      prev = tick;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (prev) begin
            found = 1'b1;
            n_checks++;
            if (count !== '0 || wrap !== 1'b1) begin
               n_fail++;
               $display("FAIL term_lowered: count=%0d wrap=%b required 0 1", count, wrap);
            end
         end
         prev = tick;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL term_lowered_timeout: no tick within 30 cycles");
      end
      terminal = 0;
      prev = tick;
      for (int i = 0; i < 40; i++) begin
         step();
         n_checks++;
         if (count !== '0 || wrap !== prev || dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL term_zero: count=%0d wrap=%b dut=%h required count=0 wrap=%b model=%h",
                     count, wrap, dut_vec, prev, mdl_vec);
         end
         prev = tick;
      end
   endtask

   task automatic test_saturation();
      int   k = 0;
      logic seen = 1'b0;
      logic prev = tick;
      set_wave(10, 10);
      for (int i = 0; i < 100; i++) begin
         step();
         n_checks++;
         if (dut_vec !== mdl_vec || sat_vec !== msat_vec) begin
            n_fail++;
            $display("FAIL sat_model: dut=%h model=%h sat=%h smodel=%h", dut_vec, mdl_vec, sat_vec, msat_vec);
         end
         if (prev) k++;
         if (prev && k >= 2) begin
            n_checks++;
            if (s_pv !== 1'b1 || s_period !== 4'd15 || s_ovf !== 1'b1 || period !== 16'd20 || overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL sat_tick: s_pv=%b s_period=%0d s_ovf=%b period=%0d ovf=%b required 1 15 1 20 0",
                        s_pv, s_period, s_ovf, period, overflow);
            end
         end
         if (seen) begin
            n_checks++;
            if (s_ovf !== 1'b1) begin
               n_fail++;
               $display("FAIL sat_sticky: s_ovf=%b required 1", s_ovf);
            end
         end
         if (s_ovf === 1'b1) seen = 1'b1;
         prev = tick;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL sat_never_set: s_ovf=%b required 1", s_ovf);
      end
      en = 1'b0;
      step();
      n_checks++;
      if (s_ovf !== 1'b0 || overflow !== 1'b0 || s_period !== 4'd15 || period !== 16'd20 || s_pv !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_en_clear: s_ovf=%b s_period=%0d period=%0d s_pv=%b required 0 15 20 0",
                  s_ovf, s_period, period, s_pv);
      end
   endtask

   task automatic test_enable_gating();
      logic found = 1'b0;
      logic prev;
      int   k = 0, nt = 0;
      terminal = 9;
      set_wave(5, 5);
      en = 1'b1;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (count == 16'd2) found = 1'b1;
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL gate_reach2: count=%0d required 2 within bound", count);
      end
      en = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick) nt++;
         n_checks++;
         if (count !== 16'd2 || wrap !== 1'b0 || period_valid !== 1'b0 || dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL gate_hold: count=%0d wrap=%b pv=%b required 2 0 0", count, wrap, period_valid);
         end
      end
      n_checks++;
      if (nt < 3) begin
         n_fail++;
         $display("FAIL gate_ticks: got %0d ticks while disabled required at least 3", nt);
      end
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (tick) found = 1'b1;
      end
      step();
      step();
      en = 1'b1;
      prev = tick;
      for (int i = 0; i < 30; i++) begin
         step();
         if (prev) k++;
         n_checks++;
         if (prev && k == 1 && (count !== 16'd3 || period_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL gate_resume1: count=%0d pv=%b required 3 0", count, period_valid);
         end else if (prev && k == 2 && (count !== 16'd4 || period_valid !== 1'b1 || period !== 16'd10)) begin
            n_fail++;
            $display("FAIL gate_resume2: count=%0d pv=%b period=%0d required 4 1 10", count, period_valid, period);
         end else if (dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL gate_model: dut=%h model=%h", dut_vec, mdl_vec);
         end
         prev = tick;
      end
      n_checks++;
      if (k < 2) begin
         n_fail++;
         $display("FAIL gate_resume_timeout: got %0d ticks required 2", k);
      end
   endtask

   task automatic test_midrun_reset();
      logic found = 1'b0;
      logic prev;
      int   k = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (tick) found = 1'b1;
      end
      repeat (3) step();
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (dut_vec !== '0 || sat_vec !== '0 || mdl_vec !== '0) begin
         n_fail++;
         $display("FAIL midrun_reset: dut=%h sat=%h model=%h required 0", dut_vec, sat_vec, mdl_vec);
      end
      step();
      step();
      rst = 1'b1;
      prev = tick;
      for (int i = 0; i < 40; i++) begin
         step();
         if (prev) k++;
         n_checks++;
         if (prev && k == 1 && (count !== 16'd1 || period_valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL restart_tick1: count=%0d pv=%b required 1 0", count, period_valid);
         end else if (prev && k == 2 && (count !== 16'd2 || period_valid !== 1'b1 || period !== 16'd10)) begin
            n_fail++;
            $display("FAIL restart_tick2: count=%0d pv=%b period=%0d required 2 1 10", count, period_valid, period);
         end else if (dut_vec !== mdl_vec) begin
            n_fail++;
            $display("FAIL restart_model: dut=%h model=%h", dut_vec, mdl_vec);
         end
         prev = tick;
      end
      n_checks++;
      if (k < 2) begin
         n_fail++;
         $display("FAIL restart_timeout: got %0d ticks required 2", k);
      end
   endtask

   task automatic test_random();
      en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) set_wave(int'($urandom_range(2, 14)), int'($urandom_range(2, 14)));
         if ($urandom_range(0, 79) == 0) en = ~en;
         if ($urandom_range(0, 39) == 0) terminal = CNT_W'($urandom_range(0, 7));
         step();
         n_checks++;
         if (dut_vec !== mdl_vec || sat_vec !== msat_vec) begin
            n_fail++;
            $display("FAIL random_model[%0d]: dut=%h model=%h sat=%h smodel=%h",
                     i, dut_vec, mdl_vec, sat_vec, msat_vec);
         end
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      test_reset();
      test_period();
      test_terminal();
      test_saturation();
      test_enable_gating();
      test_midrun_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
